// File: rtl/tracker_clk_monitor_if.sv
// tracker_clk_monitor_if: monitored clock, control and measurement results of tracker_clk_monitor.
interface tracker_clk_monitor_if #(
    parameter int CNT_W = 16
);
    logic             monclk;
    logic             enable;
    logic             fault_clr;
    logic [CNT_W-1:0] edge_count;
    logic             count_valid;
    logic             in_range;
    logic             locked;
    logic             fault;
    logic             stuck;

    modport master (
        output monclk, enable, fault_clr,
        input  edge_count, count_valid, in_range, locked, fault, stuck
    );

    modport slave (
        input  monclk, enable, fault_clr,
        output edge_count, count_valid, in_range, locked, fault, stuck
    );
endinterface

// File: rtl/tracker_clk_monitor.sv
// tracker_clk_monitor: gated edge-count frequency and lock monitor for the tracker PLL clock.
// Define TRACKER_CLK_MON_STUCK_EN to build the no-edge (STUCK) timeout.
module tracker_clk_monitor #(
    parameter int GATE_CYCLES  = 1200,
    parameter int EXPECT_EDGES = 100,
    parameter int TOL          = 2,
    parameter int LOCK_COUNT   = 4,
    parameter int CNT_W        = 16
`ifdef TRACKER_CLK_MON_STUCK_EN
    ,
    parameter int STUCK_CYCLES = 64
`endif
) (
    input  logic                 referenceclk,
    input  logic                 reset,
    tracker_clk_monitor_if.slave mon
);
    localparam int GW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, MEASURE, EVAL} state_t;

    state_t           state, state_nx;
    logic             s1, s2, s3, edge_p;
    logic [CNT_W-1:0] gate_cnt, edge_cnt, edge_nx, dev;
    logic [GW-1:0]    good_cnt;
    logic             last_gate, eval, abort, win_ok, lock_clr, fault_set, stuck_hit;

    always_ff @(posedge referenceclk or posedge reset)
        if (reset) {s1, s2, s3} <= 3'b000;
        else       {s1, s2, s3} <= {mon.monclk, s1, s2};

    assign edge_p = s2 & ~s3;

    always_ff @(posedge referenceclk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        last_gate = gate_cnt == CNT_W'(GATE_CYCLES - 1);
        eval      = state == EVAL;
        abort     = state == MEASURE && !mon.enable;
        state_nx  = state == MEASURE ? (!mon.enable ? IDLE : last_gate ? EVAL : MEASURE)
                                     : (mon.enable ? MEASURE : IDLE);
        // An edge seen during EVAL opens the next window's count
        edge_nx   = state == MEASURE && !abort ? edge_cnt + CNT_W'(edge_p && edge_cnt != '1)
                  : eval && mon.enable         ? CNT_W'(edge_p) : '0;
        dev       = edge_cnt >= CNT_W'(EXPECT_EDGES) ? edge_cnt - CNT_W'(EXPECT_EDGES)
                                                     : CNT_W'(EXPECT_EDGES) - edge_cnt;
        win_ok    = dev <= CNT_W'(TOL);
        lock_clr  = (eval && !win_ok) || abort || stuck_hit;
        fault_set = mon.locked && ((eval && !win_ok) || stuck_hit);
    end

    always_ff @(posedge referenceclk or posedge reset)
        if (reset) begin
            gate_cnt        <= '0;
            edge_cnt        <= '0;
            good_cnt        <= '0;
            mon.edge_count  <= '0;
            mon.count_valid <= 1'b0;
            mon.in_range    <= 1'b0;
            mon.locked      <= 1'b0;
            mon.fault       <= 1'b0;
        end else begin
            gate_cnt        <= state == MEASURE && state_nx == MEASURE ? gate_cnt + CNT_W'(1) : '0;
            edge_cnt        <= edge_nx;
            mon.count_valid <= eval;
            if (eval) begin
                mon.edge_count <= edge_cnt;
                mon.in_range   <= win_ok;
            end
            good_cnt   <= lock_clr ? '0
                        : eval && good_cnt != GW'(LOCK_COUNT) ? good_cnt + GW'(1) : good_cnt;
            mon.locked <= lock_clr ? 1'b0
                        : eval && good_cnt >= GW'(LOCK_COUNT - 1) ? 1'b1 : mon.locked;
            // A new loss of lock wins over a simultaneous clear request
            mon.fault  <= fault_set | (mon.fault & ~mon.fault_clr);
        end

`ifdef TRACKER_CLK_MON_STUCK_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic [SW-1:0] idle_cnt;

    assign stuck_hit = state == MEASURE && mon.enable && !edge_p && idle_cnt == SW'(STUCK_CYCLES - 1);

    always_ff @(posedge referenceclk or posedge reset)
        if (reset) begin
            idle_cnt  <= '0;
            mon.stuck <= 1'b0;
        end else begin
            idle_cnt  <= edge_p || !mon.enable || state == IDLE ? '0
                       : state == MEASURE && idle_cnt != SW'(STUCK_CYCLES) ? idle_cnt + SW'(1) : idle_cnt;
            mon.stuck <= stuck_hit ? 1'b1 : edge_p || !mon.enable ? 1'b0 : mon.stuck;
        end
`else
    assign stuck_hit = 1'b0;
    assign mon.stuck = 1'b0;
`endif
endmodule

// File: tb/tb_tracker_clk_monitor.sv
// tb_tracker_clk_monitor: vector table, directed corner sequences and randomized MONCLK periods
// checked against an edge-timestamp reference model of the gate-window monitor.
module tb_tracker_clk_monitor;
    localparam int WIN = 1201;

    typedef struct {
        int per;
        int nwin;
        bit clr;
        bit inr;
        bit lck;
        bit flt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tracker_clk_monitor_if #(.CNT_W(16)) mon_if ();

    tracker_clk_monitor dut (
        .referenceclk(clk),
        .reset       (reset),
        .mon         (mon_if)
    );

    int tests = 0, fails = 0;
    int cyc = 0, exp_m = -1, run = 0, last_rise = 0, per = 12, ph = 0;
    bit prev_mon = 0, prev_en = 0, fresh = 0, mlocked = 0, mfault = 0;
    int rises[$];
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // MONCLK generator: high for the first half of each period, held low when per == 0
    always @(negedge clk) begin
        ph = (ph + 1 >= per) ? 0 : ph + 1;
        mon_if.monclk = (per > 0) && (ph < per / 2);
    end

    // Reference model: timestamps every MONCLK rise by the REFERENCECLK edge that first samples it;
    // a window ending with COUNT_VALID at cycle m owns the rises sampled in [m-1203, m-3]
    // ([m-1202, m-3] for the first window after enable), i.e. its 1201-cycle span shifted by sync latency.
    always @(posedge clk) begin
        int n, lo, dev;
        bit set, inr;
        cyc++;
        #1;
        set = 0;
        if (reset) begin
            rises.delete();
            prev_mon = 0;
            prev_en = 0;
            run = 0;
            mlocked = 0;
            mfault = 0;
            exp_m = -1;
        end else begin
            if (mon_if.monclk && !prev_mon) begin
                rises.push_back(cyc);
                last_rise = cyc;
            end
            prev_mon = mon_if.monclk;
            if (mon_if.enable && !prev_en) begin
                exp_m = cyc + WIN;
                fresh = 1;
            end
            if (!mon_if.enable && prev_en) begin
                exp_m = -1;
                run = 0;
                mlocked = 0;
            end
            prev_en = mon_if.enable;
            if (mon_if.count_valid) begin
                chk("valid_time", cyc, exp_m);
                lo = fresh ? cyc - 1202 : cyc - 1203;
                n = 0;
                foreach (rises[i]) if (rises[i] >= lo && rises[i] <= cyc - 3) n++;
                while (rises.size() > 0 && rises[0] <= cyc - 3) void'(rises.pop_front());
                dev = n > 100 ? n - 100 : 100 - n;
                inr = dev <= 2;
                if (inr) run++;
                else begin
                    set = mlocked;
                    run = 0;
                end
                mlocked = run >= 4;
                if (set) mfault = 1;
                chk("model_edge_count", mon_if.edge_count, n);
                chk("model_in_range", mon_if.in_range, inr);
                chk("model_locked", mon_if.locked, mlocked);
                exp_m = mon_if.enable ? cyc + WIN : -1;
                fresh = 0;
            end else if (cyc == exp_m) chk("valid_missing", 0, 1);
            if (mon_if.fault_clr && !set) mfault = 0;
            if (mon_if.count_valid) chk("model_fault", mon_if.fault, mfault);
        end
    end

    task automatic wait_valid(input int n);
        int got = 0;
        int lim = n * (WIN + 20);
        while (got < n && lim > 0) begin
            @(posedge clk);
            #1;
            if (mon_if.count_valid) got++;
            lim--;
        end
        chk("valid_wait", got, n);
    endtask

    task automatic pulse_clr();
        @(negedge clk) mon_if.fault_clr = 1'b1;
        @(negedge clk) mon_if.fault_clr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int seen, start;
        mon_if.enable = 1'b1;
        mon_if.fault_clr = 1'b0;
        tbl[0] = '{12, 4, 0, 1, 1, 0};
        tbl[1] = '{10, 1, 0, 0, 0, 1};
        tbl[2] = '{11, 3, 1, 0, 0, 0};
        tbl[3] = '{12, 3, 0, 1, 0, 0};
        tbl[4] = '{12, 1, 0, 1, 1, 0};
        tbl[5] = '{13, 1, 0, 0, 0, 1};
        repeat (3) @(negedge clk);
        chk("rst_count_valid", mon_if.count_valid, 0);
        chk("rst_locked", mon_if.locked, 0);
        chk("rst_fault", mon_if.fault, 0);
        chk("rst_in_range", mon_if.in_range, 0);
        chk("rst_edge_count", mon_if.edge_count, 0);
        chk("rst_stuck", mon_if.stuck, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk) per = tbl[i].per;
            if (tbl[i].clr) pulse_clr();
            wait_valid(tbl[i].nwin);
            chk("row_in_range", mon_if.in_range, tbl[i].inr);
            chk("row_locked", mon_if.locked, tbl[i].lck);
            chk("row_fault", mon_if.fault, tbl[i].flt);
        end

        pulse_clr();
        @(posedge clk);
        #1;
        chk("fault_cleared", mon_if.fault, 0);
        @(negedge clk) per = 12;
        wait_valid(4);
        chk("relocked", mon_if.locked, 1);
        @(negedge clk) per = 10;
        for (int i = 0; i < WIN + 10 && cyc != exp_m - 1; i++) @(negedge clk);
        mon_if.fault_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("set_clr_valid", mon_if.count_valid, 1);
        chk("set_clr_fault", mon_if.fault, 1);
        chk("set_clr_locked", mon_if.locked, 0);
        @(negedge clk) mon_if.fault_clr = 1'b0;
        pulse_clr();
        @(posedge clk);
        #1;
        chk("fault_cleared2", mon_if.fault, 0);

        @(negedge clk) per = 12;
        wait_valid(4);
        chk("lock_before_disable", mon_if.locked, 1);
        repeat (600) @(negedge clk);
        mon_if.enable = 1'b0;
        @(posedge clk);
        #1;
        chk("disable_locked", mon_if.locked, 0);
        chk("disable_fault", mon_if.fault, 0);
        seen = 0;
        for (int i = 0; i < 1300; i++) begin
            @(posedge clk);
            #1;
            if (mon_if.count_valid) seen++;
        end
        chk("disable_no_valid", seen, 0);
        @(negedge clk) mon_if.enable = 1'b1;
        start = cyc + 1;
        wait_valid(1);
        chk("reenable_latency", cyc - start, WIN);
        wait_valid(2);
        chk("reenable_unlocked3", mon_if.locked, 0);
        wait_valid(1);
        chk("reenable_locked4", mon_if.locked, 1);

        repeat (300) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_locked", mon_if.locked, 0);
        chk("async_rst_fault", mon_if.fault, 0);
        chk("async_rst_edge_count", mon_if.edge_count, 0);
        chk("async_rst_in_range", mon_if.in_range, 0);
        chk("async_rst_valid", mon_if.count_valid, 0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        wait_valid(3);
        chk("post_rst_unlocked", mon_if.locked, 0);
        wait_valid(1);
        chk("post_rst_locked", mon_if.locked, 1);
        chk("post_rst_count", 32'(mon_if.edge_count >= 99 && mon_if.edge_count <= 101), 1);

        @(negedge clk) per = 0;
`ifdef TRACKER_CLK_MON_STUCK_EN
        for (int i = 0; i < 120 && !mon_if.stuck; i++) begin
            @(posedge clk);
            #1;
        end
        chk("stuck_set", mon_if.stuck, 1);
        chk("stuck_latency", 32'(cyc - last_rise >= 60 && cyc - last_rise <= 67), 1);
        chk("stuck_locked", mon_if.locked, 0);
        chk("stuck_fault", mon_if.fault, 1);
        repeat (100) @(negedge clk);
        per = 12;
        for (int i = 0; i < 40 && mon_if.stuck; i++) begin
            @(posedge clk);
            #1;
        end
        chk("stuck_cleared", mon_if.stuck, 0);
`else
        repeat (100) @(posedge clk);
        #1;
        chk("stuck_absent", mon_if.stuck, 0);
        chk("locked_until_eval", mon_if.locked, 1);
        @(negedge clk) per = 12;
`endif
        wait_valid(1);
        chk("dead_window_in_range", mon_if.in_range, 0);
        chk("dead_window_locked", mon_if.locked, 0);
        chk("dead_window_fault", mon_if.fault, 1);
        pulse_clr();

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            per = $urandom_range(10, 14);
            if ($urandom_range(0, 2) == 0) pulse_clr();
            wait_valid(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
